// File: rtl/fifo_arbiter.sv
// Two-producer round-robin arbiter feeding an external FIFO.
// Ports: clk, rst (async low), req/data/ack per producer, FIFO strobes, level, err.
module fifo_arbiter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  input  logic              pop_req,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              rd_valid,
  output logic [LW-1:0]     level,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    PUSH0,
    PUSH1
  } state_t;

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  state_t      state;
  state_t      state_nx;
  logic        last_gnt;
  logic        last_nx;
  logic        can_push;
  logic        can_pop;
  logic        elig0;
  logic        elig1;
  logic        push_nx;
  logic        pop_nx;
  logic [LW-1:0] level_nx;

  assign can_push = level < FULL;
  assign can_pop  = level != '0;

  // A producer being acked this cycle still shows req high;
  // masking it prevents a second push of the same item.
  assign elig0 = req0 & (state != PUSH0);
  assign elig1 = req1 & (state != PUSH1);

  always_comb begin
    state_nx = IDLE;
    last_nx  = last_gnt;
    if (can_push) begin
      unique case (1'b1)
        (elig0 & elig1):  state_nx = last_gnt ? PUSH0 : PUSH1;
        (elig0 & !elig1): state_nx = PUSH0;
        (!elig0 & elig1): state_nx = PUSH1;
        default:          state_nx = IDLE;
      endcase
    end
    if (state_nx == PUSH0) last_nx = 1'b0;
    if (state_nx == PUSH1) last_nx = 1'b1;
  end

  assign push_nx = state_nx != IDLE;
  assign pop_nx  = pop_req & can_pop;

  always_comb begin
    level_nx = level;
    unique case ({push_nx, pop_nx})
      2'b10:   level_nx = level + 1'b1;
      2'b01:   level_nx = level - 1'b1;
      default: level_nx = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nx;
      last_gnt <= last_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_data <= '0;
      fifo_pop  <= 1'b0;
      rd_valid  <= 1'b0;
      level     <= '0;
      err       <= 1'b0;
    end else begin
      if (state_nx == PUSH0) fifo_data <= data0;
      if (state_nx == PUSH1) fifo_data <= data1;
      fifo_pop <= pop_nx;
      rd_valid <= fifo_pop;
      level    <= level_nx;
      if ((fifo_push & fifo_full) | (fifo_pop & fifo_empty))
        err <= 1'b1;
    end
  end

  assign fifo_push = state != IDLE;
  assign ack0      = state == PUSH0;
  assign ack1      = state == PUSH1;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_fifo_arbiter;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH + 1);

  logic          clk = 0;
  logic          rst;
  logic          req0, req1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1;
  logic          pop_req;
  logic          fifo_full, fifo_empty;
  logic          fifo_push;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          err;

  int n_pass = 0;
  int n_total = 0;

  int m_level, m_last, m_gnt, m_pop, m_rdv, m_err;
  logic [DW-1:0] m_data;

  fifo_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1),
    .pop_req(pop_req),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_push(fifo_push), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .rd_valid(rd_valid),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_level = 0;
    m_last = 1;
    m_gnt = 0;
    m_pop = 0;
    m_rdv = 0;
    m_err = 0;
    m_data = '0;
  endtask

  // Model advances by the arbitration rules, then the clock edge.
  // m_gnt: 0 none, 1 producer 0, 2 producer 1.
  task automatic cycle();
    int w0, w1, g, p;
    if ((m_gnt != 0 && fifo_full) || (m_pop != 0 && fifo_empty))
      m_err = 1;
    w0 = (req0 && m_gnt != 1) ? 1 : 0;
    w1 = (req1 && m_gnt != 2) ? 1 : 0;
    g = 0;
    if (m_level < DEPTH) begin
      if (w0 == 1 && w1 == 1) g = (m_last == 0) ? 2 : 1;
      else if (w0 == 1) g = 1;
      else if (w1 == 1) g = 2;
    end
    p = (pop_req && m_level > 0) ? 1 : 0;
    if (g == 1) begin m_data = data0; m_last = 0; end
    if (g == 2) begin m_data = data1; m_last = 1; end
    m_level = m_level + ((g != 0) ? 1 : 0) - p;
    m_rdv = m_pop;
    m_pop = p;
    m_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0;
    data0 = 0; data1 = 0;
    pop_req = 0;
    fifo_full = 0; fifo_empty = 0;
  endtask

  task automatic test_reset();
    logic [DW+LW+6:0] all;
    idle_inputs();
    rst = 0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    all = {fifo_push, fifo_pop, fifo_data, ack0, ack1, rd_valid, err, level};
    n_total++;
    if (all !== '0)
      $display("FAIL reset_outputs: got %0h want 0", all);
    else n_pass++;
    rst = 1;
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1; req1 = 1;
    data0 = 8'hA0; data1 = 8'hB1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_total++;
      if ({ack0, ack1} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL tie_ack[%0d]: got %b%b", k, ack0, ack1);
      else n_pass++;
      n_total++;
      if (fifo_data !== ((k % 2 == 0) ? 8'hA0 : 8'hB1))
        $display("FAIL tie_data[%0d]: got %0h", k, fifo_data);
      else n_pass++;
      n_total++;
      if (level !== LW'(k + 1))
        $display("FAIL tie_level[%0d]: got %0d want %0d", k, level, k + 1);
      else n_pass++;
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_fill();
    int pushes = 0;
    do_reset();
    req0 = 1;
    data0 = 8'h3C;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (fifo_push === 1'b1) pushes++;
    end
    n_total++;
    if (pushes != DEPTH)
      $display("FAIL fill_pushes: got %0d want %0d", pushes, DEPTH);
    else n_pass++;
    n_total++;
    if (level !== LW'(DEPTH))
      $display("FAIL fill_level: got %0d want %0d", level, DEPTH);
    else n_pass++;
    n_total++;
    if ({fifo_push, ack0, err} !== 3'b000)
      $display("FAIL fill_idle: push/ack0/err got %b%b%b want 000",
               fifo_push, ack0, err);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    req0 = 0; req1 = 1;
    data1 = 8'h77;
    pop_req = 1;
    cycle();
    n_total++;
    if ({fifo_pop, fifo_push, level} !== {2'b10, LW'(15)})
      $display("FAIL fullpop_t: pop/push/level got %b %b %0d want 1 0 15",
               fifo_pop, fifo_push, level);
    else n_pass++;
    cycle();
    n_total++;
    if ({fifo_push, ack1, fifo_pop, rd_valid} !== 4'b1111)
      $display("FAIL fullpop_t1: push/ack1/pop/rdv got %b%b%b%b want 1111",
               fifo_push, ack1, fifo_pop, rd_valid);
    else n_pass++;
    n_total++;
    if (level !== LW'(15) || fifo_data !== 8'h77)
      $display("FAIL fullpop_t1_lvl: level %0d data %0h want 15 77",
               level, fifo_data);
    else n_pass++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_empty_pop();
    do_reset();
    pop_req = 1;
    req0 = 1;
    data0 = 8'h55;
    cycle();
    n_total++;
    if ({fifo_push, fifo_pop, level} !== {2'b10, LW'(1)} ||
        fifo_data !== 8'h55)
      $display("FAIL empty_push: push/pop/level %b %b %0d data %0h want 1 0 1 55",
               fifo_push, fifo_pop, level, fifo_data);
    else n_pass++;
    req0 = 0;
    cycle();
    n_total++;
    if ({fifo_push, fifo_pop, level} !== {2'b01, LW'(0)})
      $display("FAIL empty_pop: push/pop/level %b %b %0d want 0 1 0",
               fifo_push, fifo_pop, level);
    else n_pass++;
    cycle();
    n_total++;
    if ({rd_valid, fifo_pop, level} !== {2'b10, LW'(0)})
      $display("FAIL empty_rdv: rdv/pop/level %b %b %0d want 1 0 0",
               rd_valid, fifo_pop, level);
    else n_pass++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_err();
    int guard = 0;
    do_reset();
    req0 = 1;
    data0 = 8'h12;
    while (m_level < 3 && guard < 20) begin
      cycle();
      guard++;
    end
    n_total++;
    if (level !== LW'(3))
      $display("FAIL err_setup_level: got %0d want 3", level);
    else n_pass++;
    fifo_full = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_total++;
      if (err !== m_err[0])
        $display("FAIL err_track[%0d]: got %b want %0d", k, err, m_err);
      else n_pass++;
    end
    fifo_full = 0;
    req0 = 0;
    cycle();
    cycle();
    n_total++;
    if (err !== 1'b1)
      $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    do_reset();
    n_total++;
    if (err !== 1'b0)
      $display("FAIL err_clear: got %b want 0", err);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [DW+LW+5:0] all;
    do_reset();
    req0 = 1; req1 = 1;
    data0 = 8'hA0; data1 = 8'hB1;
    for (int k = 0; k < 7; k++) cycle();
    n_total++;
    if (level !== LW'(7) || fifo_push !== 1'b1)
      $display("FAIL mid_setup: level %0d push %b want 7 1", level, fifo_push);
    else n_pass++;
    #2;
    rst = 0;
    #1;
    all = {fifo_push, fifo_pop, fifo_data, ack0, ack1, rd_valid, level};
    n_total++;
    if (all !== '0)
      $display("FAIL mid_async: got %0h want 0", all);
    else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    cycle();
    n_total++;
    if ({ack0, ack1, level} !== {2'b10, LW'(1)})
      $display("FAIL mid_first: ack0/ack1/level %b %b %0d want 1 0 1",
               ack0, ack1, level);
    else n_pass++;
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    int pop_pct;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      pop_pct = ((k / 150) % 2 == 0) ? 20 : 75;
      pop_req = ($urandom_range(99) < pop_pct);
      cycle();
      n_total++;
      if ({fifo_push, ack0, ack1} !==
          {m_gnt != 0, m_gnt == 1, m_gnt == 2})
        $display("FAIL rnd_grant[%0d]: push/ack0/ack1 %b%b%b want gnt %0d",
                 k, fifo_push, ack0, ack1, m_gnt);
      else n_pass++;
      if (m_gnt != 0) begin
        n_total++;
        if (fifo_data !== m_data)
          $display("FAIL rnd_data[%0d]: got %0h want %0h", k, fifo_data, m_data);
        else n_pass++;
      end
      n_total++;
      if ({fifo_pop, rd_valid} !== {m_pop[0], m_rdv[0]})
        $display("FAIL rnd_pop[%0d]: pop/rdv %b%b want %0d%0d",
                 k, fifo_pop, rd_valid, m_pop, m_rdv);
      else n_pass++;
      n_total++;
      if (level !== LW'(m_level) || err !== m_err[0])
        $display("FAIL rnd_level[%0d]: level %0d err %b want %0d %0d",
                 k, level, err, m_level, m_err);
      else n_pass++;
      if (ack0 === 1'b1) begin
        req0 = $urandom_range(1);
        data0 = DW'($urandom);
      end else if (req0 === 1'b0 && $urandom_range(1) == 1) begin
        req0 = 1;
        data0 = DW'($urandom);
      end
      if (ack1 === 1'b1) begin
        req1 = $urandom_range(1);
        data1 = DW'($urandom);
      end else if (req1 === 1'b0 && $urandom_range(1) == 1) begin
        req1 = 1;
        data1 = DW'($urandom);
      end
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    test_reset();
    test_tie();
    test_fill();
    test_full_pop();
    test_empty_pop();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of the producer and FIFO data.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the FIFO capacity in entries.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-005 Ports req0 and req1, input, 1 bit each, SHALL be producer push requests, held until acknowledged.
REQ-006 Ports data0 and data1, input, DATA_W bits each, SHALL be producer data, stable while the matching req is high.
REQ-007 Ports ack0 and ack1, output, 1 bit each, SHALL be one-cycle pulses marking that the matching producer's data was accepted.
REQ-008 Port pop_req, input, 1 bit, SHALL be the consumer read request.
REQ-009 Ports fifo_full and fifo_empty, input, 1 bit each, SHALL be the FIFO status flags, used only for error checking.
REQ-010 Port fifo_push, output, 1 bit, SHALL be the FIFO write strobe, registered.
REQ-011 Port fifo_data, output, DATA_W bits, SHALL be the FIFO write data, registered.
REQ-012 Port fifo_pop, output, 1 bit, SHALL be the FIFO read strobe, registered.
REQ-013 Port rd_valid, output, 1 bit, SHALL mark that FIFO data_out is valid, asserted exactly 1 cycle after fifo_pop.
REQ-014 Port level, output, clog2(DEPTH+1) bits, SHALL be the arbiter's occupancy count.
REQ-015 Port err, output, 1 bit, SHALL be a sticky consistency-error flag.

Function
REQ-016 The push FSM SHALL have states IDLE, PUSH0 and PUSH1, registered; the state in cycle t is the grant issued in cycle t.
REQ-017 Each cycle, can_push SHALL be (level < DEPTH), using the registered level, and can_pop SHALL be (level > 0).
REQ-018 Next state SHALL be PUSH0 if req0 wins, PUSH1 if req1 wins, and IDLE if no request or !can_push.
REQ-019 With a single requester, that requester SHALL win; with both requesting, the requester other than last_gnt SHALL win.
REQ-020 last_gnt SHALL update only on an issued grant.
REQ-021 A requester whose req is high while its ack is high SHALL NOT be re-granted in the next cycle, so that no double push occurs.
REQ-022 In PUSHn, fifo_push SHALL be 1, fifo_data SHALL be datan (captured at the decision edge) and ackn SHALL be 1; in IDLE, fifo_push, ack0 and ack1 SHALL all be 0.
REQ-023 fifo_pop SHALL be registered as (pop_req & can_pop) and SHALL NOT depend on a push issued at the same edge.
REQ-024 rd_valid SHALL be fifo_pop delayed by one register.
REQ-025 level SHALL update at the same edge that asserts the strobes: +1 for push only, -1 for pop only, unchanged for both or neither.
REQ-026 level SHALL never exceed DEPTH or go below 0.
REQ-027 Simultaneous push and pop at level=DEPTH SHALL be impossible, because can_push is false there; pop proceeds and push is deferred by one cycle.
REQ-028 err SHALL set when fifo_push=1 while fifo_full=1, or when fifo_pop=1 while fifo_empty=1 (sampled in the same cycle), and SHALL clear only by reset.
REQ-029 Maximum throughput SHALL be one push and one pop per cycle.
REQ-030 Decision-to-strobe latency SHALL be 1 cycle.

Reset
REQ-031 While rst=0, the block SHALL hold state=IDLE, last_gnt=1, level=0, and fifo_push, fifo_pop, fifo_data, ack0, ack1, rd_valid and err all at 0.
REQ-032 Reset asserted mid-operation SHALL drop all strobes immediately (asynchronously) and discard any pending grant.
REQ-033 After rst rises, the first tie SHALL be won by req0.

Verification
REQ-034 Tie with round-robin: req0=req1=1 held, data0=0xA0, data1=0xB1, level=0 -> ack0, ack1, ack0, ... alternate; fifo_data sequence is A0, B1, A0, ...; level increments 1 per cycle.
REQ-035 Fill to full: req0=1 continuously, DEPTH=16 -> exactly 16 pushes; level=16; fifo_push stays 0 afterwards; ack0 stays 0 while pop_req=0; err=0.
REQ-036 Full with simultaneous pop: level=16, req1=1, pop_req=1 -> cycle t: fifo_pop=1, level=15; t+1: fifo_push=1, ack1=1, level=15 (push and pop together); rd_valid=1 at t+1.
REQ-037 Empty pop: level=0, pop_req=1, req0 pulses once -> no fifo_pop in the push cycle; fifo_pop in the next cycle; rd_valid the cycle after; level returns to 0.
REQ-038 Error detection: force fifo_full=1 while level=3 and req0=1 -> err=1 after the push cycle and stays 1 until rst=0.
REQ-039 Reset mid-burst: both producers requesting at level=7, rst=0 for 1 cycle -> all outputs 0 immediately; after release, level counts from 0 and the first ack is ack0.
